// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard/flush scheduler for the 5-stage pipeline.
// Arbitrates branch mispredict flushes, multi-cycle execute ops, load-use hazards
// and I-fetch misses into PC hold / pipeline-register stall and bubble controls.
// Outputs are Mealy (state + inputs); state, timeout timer, error flag and perf
// counter are registered.
//
// Optional feature macro: PIPE_PERF_CNT_EN (enables the stall_cycles_o counter).
//
// Ports:
//   clk_i             clock
//   rst               synchronous reset, active low
//   D_rs1_i/D_rs2_i   source registers of the decode instruction
//   D_use_rs1_i/2_i   decode instruction reads rs1 / rs2
//   E_rd_i            destination register of the execute instruction
//   E_is_load_i       execute instruction is a load
//   E_mispredict_i    branch resolved in E was mispredicted
//   E_long_start_i    first cycle of a multi-cycle execute op
//   long_done_i       multi-cycle result ready
//   imem_ready_i      fetched instruction valid this cycle
//   pc_hold_o         PC keeps value
//   F_stall_o         F/D register holds
//   F_bubble_o        F/D register loads nop
//   D_stall_o         D/E register holds
//   D_bubble_o        D/E register loads nop
//   E_stall_o         E/M register holds
//   redirect_o        PC takes corrected target
//   state_o           FSM state (0 RUN, 1 LONG, 2 IMISS)
//   err_o             sticky LONG timeout flag
//   stall_cycles_o    count of cycles with pc_hold_o set
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LONG_TMO   = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] D_rs1_i,
    input  logic [REG_ADDR_W-1:0] D_rs2_i,
    input  logic                  D_use_rs1_i,
    input  logic                  D_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] E_rd_i,
    input  logic                  E_is_load_i,
    input  logic                  E_mispredict_i,
    input  logic                  E_long_start_i,
    input  logic                  long_done_i,
    input  logic                  imem_ready_i,
    output logic                  pc_hold_o,
    output logic                  F_stall_o,
    output logic                  F_bubble_o,
    output logic                  D_stall_o,
    output logic                  D_bubble_o,
    output logic                  E_stall_o,
    output logic                  redirect_o,
    output logic [1:0]            state_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    typedef enum logic [1:0] {StRun = 2'd0, StLong = 2'd1, StImiss = 2'd2} state_e;

    localparam int unsigned TmoW = $clog2(LONG_TMO + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(LONG_TMO);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(LONG_TMO - 1);

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            luse;
    logic            run_eval;

    assign luse = E_is_load_i && (E_rd_i != '0) &&
                  ((D_use_rs1_i && (D_rs1_i == E_rd_i)) ||
                   (D_use_rs2_i && (D_rs2_i == E_rd_i)));

    always_comb begin
        pc_hold_o  = 1'b0;
        F_stall_o  = 1'b0;
        F_bubble_o = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_stall_o  = 1'b0;
        redirect_o = 1'b0;
        state_d    = state_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        run_eval   = 1'b0;

        unique case (state_q)
            StRun: run_eval = 1'b1;
            StLong: begin
                // Mispredict is ignored here: the branch cannot resolve while E is frozen.
                if (long_done_i) begin
                    state_d = StRun;
                    tmo_d   = '0;
                end else begin
                    pc_hold_o = 1'b1;
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_stall_o = 1'b1;
                    if (tmo_q < TmoMax) tmo_d = tmo_q + 1'b1;
                    if (tmo_q >= TmoLast) err_d = 1'b1;
                end
            end
            StImiss: begin
                if (E_mispredict_i) begin
                    redirect_o = 1'b1;
                    F_bubble_o = 1'b1;
                    D_bubble_o = 1'b1;
                    state_d    = StRun;
                end else if (imem_ready_i) begin
                    run_eval = 1'b1;
                end else begin
                    pc_hold_o  = 1'b1;
                    F_bubble_o = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        // Shared RUN priority chain, also used for the cycle an I-miss resolves.
        if (run_eval) begin
            state_d = StRun;
            if (E_mispredict_i) begin
                redirect_o = 1'b1;
                F_bubble_o = 1'b1;
                D_bubble_o = 1'b1;
            end else if (E_long_start_i) begin
                pc_hold_o = 1'b1;
                F_stall_o = 1'b1;
                D_stall_o = 1'b1;
                E_stall_o = 1'b1;
                state_d   = StLong;
                tmo_d     = TmoW'(1);
            end else if (luse) begin
                pc_hold_o  = 1'b1;
                F_stall_o  = 1'b1;
                D_bubble_o = 1'b1;
            end else if (!imem_ready_i) begin
                pc_hold_o  = 1'b1;
                F_bubble_o = 1'b1;
                state_d    = StImiss;
            end
        end

        // Hold the pipe flushed while reset is asserted.
        if (!rst) begin
            pc_hold_o  = 1'b0;
            F_stall_o  = 1'b0;
            F_bubble_o = 1'b1;
            D_stall_o  = 1'b0;
            D_bubble_o = 1'b1;
            E_stall_o  = 1'b0;
            redirect_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q <= StRun;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign state_o = rst ? 2'(state_q) : 2'd0;
    assign err_o   = rst & err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (pc_hold_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cycles_o = rst ? cnt_q : '0;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int LONG_TMO   = 64;
    localparam int CNT_W      = 32;

    // Hazard classes the reference model resolves each cycle to.
    localparam int KReset = 0, KNone = 1, KFlush = 2, KLong = 3, KLuse = 4, KMiss = 5;

    // Output vector order: {pc_hold, F_stall, F_bubble, D_stall, D_bubble, E_stall, redirect}
    localparam logic [6:0] OReset = 7'b0010100;
    localparam logic [6:0] ONone  = 7'b0000000;
    localparam logic [6:0] OFlush = 7'b0010101;
    localparam logic [6:0] OLong  = 7'b1101010;
    localparam logic [6:0] OLuse  = 7'b1100100;
    localparam logic [6:0] OMiss  = 7'b1010000;

    logic clk_i = 1'b0;
    logic rst;
    logic [REG_ADDR_W-1:0] D_rs1_i, D_rs2_i, E_rd_i;
    logic D_use_rs1_i, D_use_rs2_i, E_is_load_i, E_mispredict_i, E_long_start_i;
    logic long_done_i, imem_ready_i;
    logic pc_hold_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, redirect_o;
    logic [1:0] state_o;
    logic err_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [6:0] got;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state.
    int m_mode;   // 0 RUN, 1 LONG, 2 IMISS
    int m_tmo;
    bit m_err;
    logic [CNT_W-1:0] m_cnt;

    pipe_hazard_ctrl #(
        .REG_ADDR_W(REG_ADDR_W),
        .LONG_TMO  (LONG_TMO),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .D_rs1_i       (D_rs1_i),
        .D_rs2_i       (D_rs2_i),
        .D_use_rs1_i   (D_use_rs1_i),
        .D_use_rs2_i   (D_use_rs2_i),
        .E_rd_i        (E_rd_i),
        .E_is_load_i   (E_is_load_i),
        .E_mispredict_i(E_mispredict_i),
        .E_long_start_i(E_long_start_i),
        .long_done_i   (long_done_i),
        .imem_ready_i  (imem_ready_i),
        .pc_hold_o     (pc_hold_o),
        .F_stall_o     (F_stall_o),
        .F_bubble_o    (F_bubble_o),
        .D_stall_o     (D_stall_o),
        .D_bubble_o    (D_bubble_o),
        .E_stall_o     (E_stall_o),
        .redirect_o    (redirect_o),
        .state_o       (state_o),
        .err_o         (err_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    assign got = {pc_hold_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, redirect_o};

    function automatic int hazard_kind();
        bit luse;
        luse = E_is_load_i && (E_rd_i != 0) &&
               ((D_use_rs1_i && D_rs1_i == E_rd_i) || (D_use_rs2_i && D_rs2_i == E_rd_i));
        if (!rst) return KReset;
        if (m_mode == 1) return long_done_i ? KNone : KLong;
        if (m_mode == 2 && E_mispredict_i) return KFlush;
        if (m_mode == 2 && !imem_ready_i) return KMiss;
        if (E_mispredict_i) return KFlush;
        if (E_long_start_i) return KLong;
        if (luse) return KLuse;
        if (!imem_ready_i) return KMiss;
        return KNone;
    endfunction

    function automatic logic [6:0] kind_out(input int k);
        case (k)
            KReset:  return OReset;
            KFlush:  return OFlush;
            KLong:   return OLong;
            KLuse:   return OLuse;
            KMiss:   return OMiss;
            default: return ONone;
        endcase
    endfunction

    function automatic logic [6:0] exp_out();
        return kind_out(hazard_kind());
    endfunction

    function automatic logic [1:0] exp_state();
        return rst ? 2'(m_mode) : 2'd0;
    endfunction

    function automatic logic exp_err();
        return rst & m_err;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef PIPE_PERF_CNT_EN
        return rst ? m_cnt : '0;
`else
        return '0;
`endif
    endfunction

    // Advance the model by one clock from the current inputs, then step the DUT.
    task automatic advance();
        int k;
        k = hazard_kind();
        if (k == KReset) begin
            m_mode = 0; m_tmo = 0; m_err = 0; m_cnt = '0;
        end else begin
            if (kind_out(k)[6]) m_cnt = m_cnt + 1'b1;
            if (k == KLong && m_mode == 1) begin
                if (m_tmo < LONG_TMO) m_tmo = m_tmo + 1;
                if (m_tmo == LONG_TMO) m_err = 1;
            end else if (k == KLong) begin
                m_mode = 1; m_tmo = 1;
            end else if (k == KMiss) begin
                m_mode = 2;
            end else begin
                m_mode = 0; m_tmo = 0;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic set_idle();
        D_rs1_i = '0; D_rs2_i = '0; E_rd_i = '0;
        D_use_rs1_i = 0; D_use_rs2_i = 0; E_is_load_i = 0;
        E_mispredict_i = 0; E_long_start_i = 0; long_done_i = 0; imem_ready_i = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            D_rs1_i = 5'($urandom); E_rd_i = 5'($urandom); E_is_load_i = 1'($urandom);
            E_mispredict_i = 1'($urandom); E_long_start_i = 1'($urandom);
            imem_ready_i = 1'($urandom);
            #1;
            n_cmp++;
            if (got !== OReset || state_o !== 2'd0 || err_o !== 1'b0 || stall_cycles_o !== '0) begin
                n_fail++;
                $display("FAIL reset: outs=%b state=%0d err=%b cnt=%0d, want outs=%b state=0 err=0 cnt=0",
                         got, state_o, err_o, stall_cycles_o, OReset);
            end
            advance();
        end
        rst = 1;
        set_idle();
        #1;
        n_cmp++;
        if (got !== ONone || state_o !== 2'd0 || err_o !== 1'b0 || stall_cycles_o !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outs=%b state=%0d err=%b cnt=%0d, want all 0",
                     got, state_o, err_o, stall_cycles_o);
        end
        advance();
    endtask

    task automatic test_load_use();
        set_idle();
        E_is_load_i = 1; E_rd_i = 5; D_rs1_i = 5; D_use_rs1_i = 1;
        #1;
        n_cmp++;
        if (got !== OLuse || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use: outs=%b state=%0d, want outs=%b state=0", got, state_o, OLuse);
        end
        advance();
        // The bubble has moved into E, so the load is gone.
        E_is_load_i = 0;
        #1;
        n_cmp++;
        if (got !== ONone) begin
            n_fail++;
            $display("FAIL load_use_after: outs=%b, want %b", got, ONone);
        end
        advance();
        // rs2 match path
        set_idle();
        E_is_load_i = 1; E_rd_i = 17; D_rs2_i = 17; D_use_rs2_i = 1; D_rs1_i = 17;
        #1;
        n_cmp++;
        if (got !== OLuse) begin
            n_fail++;
            $display("FAIL load_use_rs2: outs=%b, want %b", got, OLuse);
        end
        advance();
        // register match but source not used
        D_use_rs2_i = 0;
        #1;
        n_cmp++;
        if (got !== ONone) begin
            n_fail++;
            $display("FAIL load_use_unused: outs=%b, want %b", got, ONone);
        end
        advance();
    endtask

    task automatic test_rd_zero();
        set_idle();
        E_is_load_i = 1; E_rd_i = 0; D_rs1_i = 0; D_use_rs1_i = 1;
        #1;
        n_cmp++;
        if (got !== ONone) begin
            n_fail++;
            $display("FAIL rd_zero: outs=%b, want %b", got, ONone);
        end
        advance();
    endtask

    task automatic test_mispredict_long();
        set_idle();
        E_mispredict_i = 1; E_long_start_i = 1; E_is_load_i = 1; E_rd_i = 3;
        D_rs1_i = 3; D_use_rs1_i = 1; imem_ready_i = 0;
        #1;
        n_cmp++;
        if (got !== OFlush || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL mispredict_long: outs=%b state=%0d, want outs=%b state=0",
                     got, state_o, OFlush);
        end
        advance();
        set_idle();
        #1;
        n_cmp++;
        if (got !== ONone || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL mispredict_long_next: outs=%b state=%0d, want all 0", got, state_o);
        end
        advance();
    endtask

    task automatic test_long_op();
        int holds;
        holds = 0;
        set_idle();
        E_long_start_i = 1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) begin E_long_start_i = 0; E_mispredict_i = 1; end
            if (c == 11) begin long_done_i = 1; E_mispredict_i = 0; end
            if (c == 12) long_done_i = 0;
            #1;
            if (pc_hold_o) holds++;
            n_cmp++;
            if ({got, state_o, err_o, stall_cycles_o} !==
                {(c <= 10) ? OLong : ONone, (c >= 1 && c <= 11) ? 2'd1 : 2'd0, 1'b0, exp_cnt()}) begin
                n_fail++;
                $display("FAIL long_op c=%0d: outs=%b state=%0d err=%b cnt=%0d, want outs=%b cnt=%0d",
                         c, got, state_o, err_o, stall_cycles_o, (c <= 10) ? OLong : ONone, exp_cnt());
            end
            advance();
        end
        n_cmp++;
        if (holds != 11) begin
            n_fail++;
            $display("FAIL long_op_len: hold cycles=%0d, want 11", holds);
        end
    endtask

    task automatic test_timeout();
        set_idle();
        E_long_start_i = 1;
        for (int c = 0; c <= 70; c++) begin
            if (c == 1) E_long_start_i = 0;
            #1;
            n_cmp++;
            if (err_o !== ((c >= LONG_TMO) ? 1'b1 : 1'b0) || state_o !== ((c >= 1) ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL timeout c=%0d: err=%b state=%0d, want err=%b", c, err_o, state_o,
                         (c >= LONG_TMO) ? 1'b1 : 1'b0);
            end
            advance();
        end
        long_done_i = 1;
        #1;
        advance();
        long_done_i = 0;
        #1;
        n_cmp++;
        if (err_o !== 1'b1 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b state=%0d, want err=1 state=0", err_o, state_o);
        end
        rst = 0;
        advance();
        rst = 1;
        #1;
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b, want 0", err_o);
        end
        advance();
    endtask

    task automatic test_imiss_mispredict();
        logic [6:0] want_o [3];
        logic [1:0] want_s [3];
        want_o[0] = OMiss;  want_s[0] = 2'd0;
        want_o[1] = OFlush; want_s[1] = 2'd2;
        want_o[2] = OMiss;  want_s[2] = 2'd0;
        set_idle();
        imem_ready_i = 0;
        for (int c = 0; c < 3; c++) begin
            E_mispredict_i = (c == 1);
            #1;
            n_cmp++;
            if (got !== want_o[c] || state_o !== want_s[c]) begin
                n_fail++;
                $display("FAIL imiss_mispredict c=%0d: outs=%b state=%0d, want outs=%b state=%0d",
                         c, got, state_o, want_o[c], want_s[c]);
            end
            advance();
        end
        set_idle();
        #1;
        n_cmp++;
        if (got !== ONone || state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL imiss_resolve: outs=%b state=%0d, want outs=0 state=2", got, state_o);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 99) >= 2);
            D_rs1_i        = 5'($urandom_range(0, 3));
            D_rs2_i        = 5'($urandom_range(0, 3));
            E_rd_i         = 5'($urandom_range(0, 3));
            D_use_rs1_i    = 1'($urandom);
            D_use_rs2_i    = 1'($urandom);
            E_is_load_i    = 1'($urandom);
            E_mispredict_i = ($urandom_range(0, 99) < 10);
            E_long_start_i = ($urandom_range(0, 99) < 6);
            long_done_i    = ($urandom_range(0, 99) < 15);
            imem_ready_i   = ($urandom_range(0, 99) < 75);
            #1;
            n_cmp++;
            if ({got, state_o, err_o, stall_cycles_o} !==
                {exp_out(), exp_state(), exp_err(), exp_cnt()}) begin
                n_fail++;
                $display("FAIL random i=%0d: outs=%b state=%0d err=%b cnt=%0d, want outs=%b state=%0d err=%b cnt=%0d",
                         i, got, state_o, err_o, stall_cycles_o,
                         exp_out(), exp_state(), exp_err(), exp_cnt());
            end
            advance();
        end
        rst = 1;
    endtask

    initial begin
        rst = 0;
        set_idle();
        m_mode = 0; m_tmo = 0; m_err = 0; m_cnt = '0;
        @(negedge clk_i);
        test_reset();
        test_load_use();
        test_rd_zero();
        test_mispredict_long();
        test_long_op();
        test_timeout();
        test_imiss_mispredict();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
